// File: rtl/common_pkg.sv
// Shared types for the boot loader: FSM state encoding and length-header size.
package common_pkg;

    typedef enum logic [1:0] {
        ST_LEN,
        ST_DATA,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    localparam int BOOT_LEN_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed program from the UART into instruction
// memory, then releases the fetch stage and hands it the memory address port.
import common_pkg::*;

module imem_boot_loader #(
    parameter int IMEM_BYTES     = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        reload,
    input  logic [31:0] fetch_pc,
    output logic [31:0] imem_byte_address,
    output logic        imem_write_enable,
    output logic [31:0] imem_write_data,
    output logic        core_rst,
    output logic        loading,
    output logic        load_error
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [31:0] MEM_LIMIT = 32'(IMEM_BYTES);
    localparam logic [1:0] LEN_LAST = 2'(BOOT_LEN_BYTES - 1);

    boot_state_t       state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [1:0]        len_cnt_q, len_cnt_d;
    logic [31:0]       k_q, k_d;
    logic [31:0]       buf_q, buf_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [31:0]       addr_q, addr_d;
    logic              core_rst_q, core_rst_d;

    logic [31:0]       byte_ext;
    logic [31:0]       len_next;
    logic [31:0]       word_next;
    logic [IDLE_W-1:0] idle_sat;

    assign byte_ext  = {24'd0, rx_data};
    assign len_next  = len_q | (byte_ext << {len_cnt_q, 3'b000});
    assign word_next = buf_q | (byte_ext << {k_q[1:0], 3'b000});
    assign idle_sat  = (idle_q == IDLE_MAX) ? IDLE_MAX
                                            : idle_q + IDLE_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        len_cnt_d  = len_cnt_q;
        k_d        = k_q;
        buf_d      = buf_q;
        idle_d     = idle_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        addr_d     = addr_q;
        core_rst_d = 1'b1;

        if (reload) begin
            state_d   = ST_LEN;
            len_d     = '0;
            len_cnt_d = '0;
            k_d       = '0;
            buf_d     = '0;
            idle_d    = '0;
            wr_data_d = '0;
            addr_d    = '0;
        end else begin
            unique case (state_q)
                ST_LEN: begin
                    if (rx_valid) begin
                        idle_d = '0;
                        len_d  = len_next;
                        if (len_cnt_q == LEN_LAST) begin
                            len_cnt_d = '0;
                            k_d       = '0;
                            if (len_next == 32'd0)
                                state_d = ST_RUN;
                            else if (len_next > MEM_LIMIT)
                                state_d = ST_ERROR;
                            else
                                state_d = ST_DATA;
                        end else begin
                            len_cnt_d = len_cnt_q + 2'd1;
                        end
                    end else if (len_cnt_q != 2'd0) begin
                        idle_d = idle_sat;
                        if (idle_sat == IDLE_MAX)
                            state_d = ST_ERROR;
                    end
                end
                ST_DATA: begin
                    // k == N only in the final strobe cycle
                    if (k_q == len_q) begin
                        state_d = ST_RUN;
                    end else if (rx_valid) begin
                        idle_d = '0;
                        k_d    = k_q + 32'd1;
                        if (k_q[1:0] == 2'd3 ||
                            k_q == len_q - 32'd1) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = word_next;
                            addr_d    = {k_q[31:2], 2'b00};
                            buf_d     = '0;
                        end else begin
                            buf_d = word_next;
                        end
                    end else begin
                        idle_d = idle_sat;
                        if (idle_sat == IDLE_MAX)
                            state_d = ST_ERROR;
                    end
                end
                ST_RUN: begin
                    core_rst_d = 1'b0;
                end
                ST_ERROR: begin
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LEN;
            len_q      <= '0;
            len_cnt_q  <= '0;
            k_q        <= '0;
            buf_q      <= '0;
            idle_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            addr_q     <= '0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            len_cnt_q  <= len_cnt_d;
            k_q        <= k_d;
            buf_q      <= buf_d;
            idle_q     <= idle_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            addr_q     <= addr_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign imem_byte_address = (state_q == ST_RUN) ? fetch_pc : addr_q;
    assign imem_write_enable = wr_en_q;
    assign imem_write_data   = wr_data_q;
    assign core_rst          = core_rst_q;
    assign loading           = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign load_error        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table-driven random loads checked
// against a byte-stream word model, plus timeout and reload corner sequences.
module tb_imem_boot_loader;

    localparam int IMEM = 256;
    localparam int TMO  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        reload = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic [31:0] imem_byte_address;
    logic        imem_write_enable;
    logic [31:0] imem_write_data;
    logic        core_rst;
    logic        loading;
    logic        load_error;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .IMEM_BYTES    (IMEM),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .reload           (reload),
        .fetch_pc         (fetch_pc),
        .imem_byte_address(imem_byte_address),
        .imem_write_enable(imem_write_enable),
        .imem_write_data  (imem_write_data),
        .core_rst         (core_rst),
        .loading          (loading),
        .load_error       (load_error)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [7:0]  data[$];

    always @(negedge clk) begin
        if (imem_write_enable) begin
            got_a.push_back(imem_byte_address);
            got_d.push_back(imem_write_data);
        end
    end

    typedef struct {
        string name;
        int    len;
        int    nsend;
        int    gap;
        bit    exp_err;
        int    exp_writes;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reload;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_writes;
        got_a.delete();
        got_d.delete();
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    // Word w of the image: bytes 4w..4w+3 of the stream, little-endian,
    // bytes at or beyond the declared length read as zero.
    function automatic logic [31:0] model_word(input int n, input int w);
        logic [31:0] word;
        word = 32'd0;
        for (int lane = 0; lane < 4; lane++) begin
            if (4*w + lane < n) word[8*lane +: 8] = data[4*w + lane];
        end
        return word;
    endfunction

    task automatic check_writes(input string nm, input int n,
                                input int exp_cnt);
        int m;
        chk($sformatf("%s wr_count", nm), 32'(got_a.size()), 32'(exp_cnt));
        m = (got_a.size() < exp_cnt) ? got_a.size() : exp_cnt;
        for (int w = 0; w < m; w++) begin
            chk($sformatf("%s addr[%0d]", nm, w), got_a[w], 32'(4*w));
            chk($sformatf("%s data[%0d]", nm, w), got_d[w], model_word(n, w));
        end
    endtask

    initial begin
        vt[0] = '{"b2b_len8",  8,   8,   0, 1'b0, 2};
        vt[1] = '{"len6",      6,   6,   1, 1'b0, 2};
        vt[2] = '{"len0",      0,   0,   0, 1'b0, 0};
        vt[3] = '{"over4",     IMEM+4, 5, 0, 1'b1, 0};
        vt[4] = '{"full",      IMEM, IMEM, 1, 1'b0, IMEM/4};
        vt[5] = '{"len1",      1,   1,   2, 1'b0, 1};
        vt[6] = '{"len13",     13,  13,  2, 1'b0, 4};
        vt[7] = '{"over1",     IMEM+1, 3, 0, 1'b1, 0};

        // reset values while reset is held
        idle(2);
        chk("rst loading",  32'(loading), 32'd1);
        chk("rst core_rst", 32'(core_rst), 32'd1);
        chk("rst load_err", 32'(load_error), 32'd0);
        chk("rst wr_en",    32'(imem_write_enable), 32'd0);
        chk("rst wr_data",  imem_write_data, 32'd0);
        chk("rst addr",     imem_byte_address, 32'd0);
        rst = 1'b1;
        idle(1);

        // known program, with cycle-exact hand-over to the fetch stage
        clear_writes();
        data = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send_len(32'd8);
        for (int i = 0; i < 8; i++) send_byte(data[i]);
        chk("prog last strobe", 32'(imem_write_enable), 32'd1);
        chk("prog last addr",   imem_byte_address, 32'd4);
        chk("prog last data",   imem_write_data, 32'h0010_0593);
        chk("prog strobe crst", 32'(core_rst), 32'd1);
        idle(1);
        chk("prog run wr_en",   32'(imem_write_enable), 32'd0);
        chk("prog run loading", 32'(loading), 32'd0);
        chk("prog run crst1",   32'(core_rst), 32'd1);
        idle(1);
        chk("prog run crst0",   32'(core_rst), 32'd0);
        for (int i = 0; i < 3; i++) begin
            fetch_pc = $urandom;
            #1;
            chk("prog fetch_pc", imem_byte_address, fetch_pc);
            idle(1);
        end
        send_byte(8'hAA);
        send_byte(8'h55);
        idle(2);
        check_writes("prog", 8, 2);
        chk("prog word0", got_d[0], 32'h0000_0513);

        // table of randomised loads
        foreach (vt[v]) begin
            do_reload();
            clear_writes();
            data.delete();
            for (int i = 0; i < vt[v].nsend; i++)
                data.push_back(8'($urandom_range(0, 255)));
            send_len(32'(vt[v].len));
            for (int i = 0; i < vt[v].nsend; i++) begin
                if (vt[v].gap > 0) idle($urandom_range(0, vt[v].gap));
                send_byte(data[i]);
            end
            idle(4);
            chk($sformatf("%s load_error", vt[v].name),
                32'(load_error), 32'(vt[v].exp_err));
            chk($sformatf("%s core_rst", vt[v].name),
                32'(core_rst), 32'(vt[v].exp_err));
            chk($sformatf("%s loading", vt[v].name), 32'(loading), 32'd0);
            check_writes(vt[v].name, vt[v].len, vt[v].exp_writes);
        end

        // timeout: none before the first length byte, then mid-data
        do_reload();
        clear_writes();
        idle(2*TMO);
        chk("tmo len idle err", 32'(load_error), 32'd0);
        data.delete();
        for (int i = 0; i < 8; i++) data.push_back(8'($urandom));
        send_len(32'd8);
        for (int i = 0; i < 3; i++) send_byte(data[i]);
        idle(TMO - 5);
        chk("tmo early err", 32'(load_error), 32'd0);
        chk("tmo early load", 32'(loading), 32'd1);
        idle(10);
        chk("tmo err", 32'(load_error), 32'd1);
        chk("tmo crst", 32'(core_rst), 32'd1);
        chk("tmo loading", 32'(loading), 32'd0);
        for (int i = 3; i < 8; i++) send_byte(data[i]);
        idle(2);
        chk("tmo wr_count", 32'(got_a.size()), 32'd0);
        do_reload();
        chk("tmo reload load", 32'(loading), 32'd1);
        chk("tmo reload err", 32'(load_error), 32'd0);
        data.delete();
        for (int i = 0; i < 4; i++) data.push_back(8'($urandom));
        send_len(32'd4);
        for (int i = 0; i < 4; i++) send_byte(data[i]);
        idle(4);
        chk("tmo reload crst", 32'(core_rst), 32'd0);
        check_writes("tmo reload", 4, 1);

        // reload coinciding with the byte that would trigger a write
        do_reload();
        clear_writes();
        data.delete();
        for (int i = 0; i < 8; i++) data.push_back(8'($urandom));
        send_len(32'd8);
        for (int i = 0; i < 7; i++) send_byte(data[i]);
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = data[7];
        @(negedge clk);
        reload   = 1'b0;
        rx_valid = 1'b0;
        chk("rl strobe", 32'(imem_write_enable), 32'd0);
        chk("rl addr", imem_byte_address, 32'd0);
        chk("rl loading", 32'(loading), 32'd1);
        idle(3);
        check_writes("rl", 8, 1);
        send_len(32'd0);
        idle(3);
        chk("rl len0 crst", 32'(core_rst), 32'd0);
        chk("rl len0 wr", 32'(got_a.size()), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
